// File: rtl/tmds_chnl_bond_pkg.sv
// Shared constants and types for the TMDS channel-bonding (lane deskew) block.
package tmds_chnl_bond_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  localparam logic [9:0] CTKN_0 = 10'h354;
  localparam logic [9:0] CTKN_1 = 10'h0AB;
  localparam logic [9:0] CTKN_2 = 10'h154;
  localparam logic [9:0] CTKN_3 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SKIP,
    ST_READY
  } bond_state_e;

  function automatic logic is_ctkn(input logic [9:0] chr);
    return (chr == CTKN_0) || (chr == CTKN_1) || (chr == CTKN_2) || (chr == CTKN_3);
  endfunction

endpackage

// File: rtl/bond_dpram16.sv
// 16-entry deskew buffer: synchronous write port, asynchronous read port.
module bond_dpram16
  import tmds_chnl_bond_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] wa_i,
  input  logic [DATA_W-1:0]     wd_i,
  input  logic [DEPTH_LOG2-1:0] ra_i,
  output logic [DATA_W-1:0]     rd_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset so it maps onto distributed RAM;
  // the read pointer always trails the write pointer, so stale words are never read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/tmds_chnl_bond.sv
// Per-lane TMDS deskew: buffers characters and parks the read pointer on the
// second blank-begin token until all three lanes are parked, then streams aligned.
module tmds_chnl_bond
  import tmds_chnl_bond_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] RAW_DATA,
  input  logic              IAM_VLD,
  input  logic [1:0]        OTHER_VLD,
  input  logic [1:0]        OTHER_RDY,
  output logic              IAM_RDY,
  output logic [DATA_W-1:0] S_DATA
);

  bond_state_e           state_q, state_d;
  logic [DEPTH_LOG2-1:0] wa_q, wa_d;
  logic [DEPTH_LOG2-1:0] ra_q, ra_d;
  logic [DATA_W-1:0]     s_data_q, s_data_d;
  logic                  ctkn_q, ctkn_d;
  logic [DATA_W-1:0]     rd_data;
  logic                  all_vld, all_rdy, iam_rdy, cur_ctkn, blnk_bgn;

  assign all_vld  = IAM_VLD & OTHER_VLD[0] & OTHER_VLD[1];
  assign cur_ctkn = is_ctkn(s_data_q[9:0]);
  assign blnk_bgn = cur_ctkn & ~ctkn_q;

  // Ready is raised in the very cycle SKIP sees its blank-begin so the read
  // pointer parks on the token that follows; losing lock wins over that edge.
  assign iam_rdy  = (state_q == ST_READY) |
                    ((state_q == ST_SKIP) & blnk_bgn & all_vld);
  assign all_rdy  = iam_rdy & OTHER_RDY[0] & OTHER_RDY[1];
  assign IAM_RDY  = iam_rdy;
  assign S_DATA   = s_data_q;

  bond_dpram16 #(.DATA_W(DATA_W)) u_dpram (
    .clk  (CLK),
    .we_i (all_vld),
    .wa_i (wa_q),
    .wd_i (RAW_DATA),
    .ra_i (ra_q),
    .rd_o (rd_data)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (all_vld)  state_d = ST_SEARCH;
      ST_SEARCH: if (blnk_bgn) state_d = ST_SKIP;
      ST_SKIP:   if (blnk_bgn) state_d = ST_READY;
      ST_READY:  state_d = ST_READY;
    endcase
    if (!all_vld) state_d = ST_IDLE;
  end

  // RA stays at 0 through the IDLE cycle while WA advances, so reads trail
  // writes by one entry and each cycle of hold adds one character of delay.
  always_comb begin
    wa_d     = all_vld ? wa_q + DEPTH_LOG2'(1) : '0;
    ra_d     = ra_q + DEPTH_LOG2'(1);
    if (!all_vld || state_q == ST_IDLE) ra_d = '0;
    else if (iam_rdy && !all_rdy)       ra_d = ra_q;
    ctkn_d   = all_vld & cur_ctkn;
    s_data_d = (all_vld && state_q != ST_IDLE) ? rd_data : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      wa_q     <= '0;
      ra_q     <= '0;
      ctkn_q   <= 1'b0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      wa_q     <= wa_d;
      ra_q     <= ra_d;
      ctkn_q   <= ctkn_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: tb/tb_tmds_chnl_bond.sv
// Three bonded lanes driven from one character stream with per-lane skew,
// checked every cycle against a stream-level reference model.
module tb_tmds_chnl_bond;

  localparam int W  = 10;
  localparam int NB = 2048;
  localparam int TK = 1024;  // symbols >= TK are control tokens of kind (sym-TK)
  localparam logic [W-1:0] TOK_TBL [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   vld;
  logic [2:0]   rdy;
  logic [W-1:0] raw  [3];
  logic [W-1:0] sdat [3];

  for (genvar L = 0; L < 3; L++) begin : g_lane
    tmds_chnl_bond #(.DATA_W(W)) u_dut (
      .CLK       (clk),
      .RESET_N   (rst_n),
      .RAW_DATA  (raw[L]),
      .IAM_VLD   (vld[L]),
      .OTHER_VLD ({vld[(L+2)%3], vld[(L+1)%3]}),
      .OTHER_RDY ({rdy[(L+2)%3], rdy[(L+1)%3]}),
      .IAM_RDY   (rdy[L]),
      .S_DATA    (sdat[L])
    );
  end

  int           n_vec, n_miss, cyc;
  int           base [NB];
  bit           allv_h [NB];
  logic [W-1:0] sexp_h [3][NB];
  int           skew [3];
  int           nbb [3];
  int           r_l [3];
  logic [W-1:0] park [3];
  int           r_all;

  function automatic bit is_tok(input logic [W-1:0] v);
    return (v == 10'h354) || (v == 10'h0AB) || (v == 10'h154) || (v == 10'h2AB);
  endfunction

  function automatic int rand_data();
    int v;
    do v = int'($urandom_range(0, 1023)); while (is_tok(W'(v)));
    return v;
  endfunction

  function automatic int base_at(input int i);
    return (i < 0) ? 0 : base[i];
  endfunction

  // Each lane carries the same data words; token kind k maps to a lane-specific token.
  function automatic logic [W-1:0] lane_char(input int sym, input int lane);
    if (sym >= TK) return TOK_TBL[(sym - TK + lane) % 4];
    return W'(sym);
  endfunction

  function automatic int max_skew();
    int m = 0;
    for (int i = 0; i < 3; i++) if (skew[i] > m) m = skew[i];
    return m;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s cyc%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: output lags its lane input by 2 until the lane has seen two
  // blank-begins; it then repeats the token until every lane is ready, after
  // which all lanes follow the most-delayed lane in lock-step.
  task automatic model_check(input bit allv);
    bit           live, bb, er;
    logic [W-1:0] e, prev;
    allv_h[cyc] = allv;
    live = (cyc >= 2) && allv_h[cyc-1] && allv_h[cyc-2];
    for (int L = 0; L < 3; L++) begin
      if (!live)             e = '0;
      else if (r_all >= 0)   e = lane_char(base_at(cyc - 2 - max_skew()), L);
      else if (r_l[L] >= 0)  e = park[L];
      else                   e = lane_char(base_at(cyc - 2 - skew[L]), L);
      sexp_h[L][cyc] = e;
      check($sformatf("sdata_lane%0d", L), sdat[L], e);
      prev = (cyc >= 1) ? sexp_h[L][cyc-1] : '0;
      bb   = allv && is_tok(e) && !is_tok(prev);
      if (bb && nbb[L] < 2) nbb[L]++;
      er = (nbb[L] >= 2);
      if (er && r_l[L] < 0) begin
        r_l[L]  = cyc;
        park[L] = e;
      end
      check($sformatf("iam_rdy_lane%0d", L), W'(rdy[L]), W'(er));
    end
    if (allv && r_all < 0 && r_l[0] >= 0 && r_l[1] >= 0 && r_l[2] >= 0) r_all = cyc;
    if (!allv) begin
      for (int L = 0; L < 3; L++) begin
        nbb[L] = 0;
        r_l[L] = -1;
      end
      r_all = -1;
    end
  endtask

  task automatic step(input int sym, input logic [2:0] vm);
    base[cyc] = sym;
    vld = vm;
    for (int L = 0; L < 3; L++) raw[L] = lane_char(base_at(cyc - skew[L]), L);
    @(negedge clk);
    model_check((vm == 3'b111) && (rst_n == 1'b1));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic data(input int n, input logic [2:0] vm);
    for (int i = 0; i < n; i++) step(rand_data(), vm);
  endtask

  task automatic toks(input int n, input int kind);
    for (int i = 0; i < n; i++) step(TK + kind, 3'b111);
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    cyc = 0;
    r_all = -1;
    for (int L = 0; L < 3; L++) begin
      skew[L] = 0;
      nbb[L]  = 0;
      r_l[L]  = -1;
      park[L] = '0;
      raw[L]  = '0;
    end
    rst_n = 1'b0;
    vld   = 3'b000;
    @(posedge clk);
    #1;

    // Reset held with toggling stimulus, then released with lock absent.
    for (int i = 0; i < 6; i++) step(rand_data(), 3'($urandom_range(0, 7)));
    rst_n = 1'b1;
    data(4, 3'b000);

    // Zero skew: two token runs to lock, then a long run through pointer wrap.
    data(20, 3'b111);
    toks(4, 0);
    data(20, 3'b111);
    toks(4, 0);
    data(45, 3'b111);
    toks(4, 2);
    data(10, 3'b111);

    // Lock loss for one cycle while ready, then partial reacquisition.
    data(1, 3'b101);
    data(8, 3'b111);
    toks(4, 3);
    data(10, 3'b111);

    // Second blank-begin coincides with the fall of lock.
    toks(2, 1);
    data(1, 3'b101);
    data(6, 3'b111);

    // Skewed lanes: lane 1 delayed 3, lane 2 delayed 7.
    data(10, 3'b000);
    skew[1] = 3;
    skew[2] = 7;
    data(20, 3'b111);
    toks(4, 0);
    data(20, 3'b111);
    toks(4, 0);
    data(45, 3'b111);
    toks(4, 2);
    data(10, 3'b111);

    // Lock loss under skew; one fresh blank-begin is not enough to be ready.
    data(1, 3'b011);
    data(10, 3'b111);
    toks(4, 1);
    data(15, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
